gcd_batch_streamer: RTL

- Walks a list of operand pairs in an external synchronous-read memory and computes the GCD of each pair.
- Streams each result out as one SPI (mode 0) frame.
- Stops at a zero terminator or at the end of the address space.
- Parametrised in data width, address width and SPI rate. Started by a single-cycle pulse, not a button edge.
- Sits between the block-memory instance and the SPI pins in the top level.

---
 rtl/gcd_batch_streamer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/gcd_batch_streamer.sv
// Reads operand pairs from a synchronous-read memory, reduces each pair to its GCD
// by repeated subtraction, and shifts every result out as one SPI mode-0 frame.
module gcd_batch_streamer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CLK_DIV    = 626,
    parameter int unsigned MSB_FIRST  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  mem_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  finished,
    output logic [ADDR_WIDTH-1:0] pair_count,
    output logic                  mosi,
    output logic                  slave_select,
    output logic                  spi_clock
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]    BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0] ADDR_MAX = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE, S_READ_X, S_CHECK_X, S_CHECK_Y, S_COMPUTE, S_SEND, S_GAP, S_DONE
    } state_t;

    state_t                  state, next_state;
    logic [ADDR_WIDTH-1:0]   pointer;
    logic [DATA_WIDTH-1:0]   op_a, op_b, shreg;
    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    div_done, last_bit, gcd_done, pair_wraps;

    function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_WIDTH-1] : v[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    assign div_done   = (div_cnt == DIV_LAST);
    assign last_bit   = (bit_cnt == BIT_LAST);
    assign gcd_done   = (op_a == op_b) || (op_b == '0);
    // A pair starting at pointer+2 would need pointer+3, so stop before the address wraps.
    assign pair_wraps = ({1'b0, pointer} + (ADDR_WIDTH+1)'(2)) > ADDR_MAX;

    assign busy         = (state != S_IDLE);
    assign finished     = (state == S_DONE);
    assign slave_select = (state != S_SEND);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        next_state  = state;
        mem_enable  = 1'b0;
        mem_address = '0;
        case (state)
            S_IDLE:    if (start) next_state = S_READ_X;
            S_READ_X: begin
                mem_enable  = 1'b1;
                mem_address = pointer;
                next_state  = S_CHECK_X;
            end
            S_CHECK_X: begin
                if (mem_data == '0) begin
                    next_state = S_DONE;
                end else begin
                    mem_enable  = 1'b1;
                    mem_address = pointer + ADDR_WIDTH'(1);
                    next_state  = S_CHECK_Y;
                end
            end
            S_CHECK_Y: next_state = S_COMPUTE;
            S_COMPUTE: if (gcd_done) next_state = S_SEND;
            S_SEND:    if (spi_clock && div_done && last_bit) next_state = S_GAP;
            S_GAP:     if (div_done) next_state = pair_wraps ? S_DONE : S_READ_X;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pointer    <= '0;
            op_a       <= '0;
            op_b       <= '0;
            shreg      <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            pair_count <= '0;
            mosi       <= 1'b0;
            spi_clock  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pair_count <= '0;
                        pointer    <= '0;
                    end
                end
                S_CHECK_X: op_a <= mem_data;
                S_CHECK_Y: op_b <= mem_data;
                S_COMPUTE: begin
                    if (gcd_done) begin
                        shreg   <= op_a;
                        mosi    <= lead_bit(op_a);
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end else if (op_a > op_b) begin
                        op_a <= op_a - op_b;
                    end else begin
                        op_b <= op_b - op_a;
                    end
                end
                S_SEND: begin
                    if (!div_done) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!spi_clock) begin
                            spi_clock <= 1'b1;
                        end else begin
                            // Falling edge: either the frame ends or the next bit is presented.
                            spi_clock <= 1'b0;
                            if (last_bit) begin
                                if (pair_count != '1) pair_count <= pair_count + ADDR_WIDTH'(1);
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                                shreg   <= shift_out(shreg);
                                mosi    <= lead_bit(shift_out(shreg));
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (!div_done) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!pair_wraps) pointer <= pointer + ADDR_WIDTH'(2);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
